// File: rtl/triggered_capture_memory.sv
// Multi-channel capture memory for ADC sample vectors.
// One-shot capture fills the whole array from address 0; triggered capture
// runs a circular buffer, keeps pre_count vectors ahead of a qualified
// trigger and then fills the rest of the array. Reads use logical addresses
// (0 = oldest captured vector) that are rotated by the capture start pointer.
module triggered_capture_memory #(
   parameter int N_CH   = 18,
   parameter int N_BITS = 8,
   parameter int N_ADDR = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH*N_BITS-1:0]   in_data,
   input  logic                     in_valid,
   input  logic                     arm,
   input  logic                     mode,
   input  logic                     trig,
   input  logic [N_ADDR-1:0]        pre_count,
   input  logic [N_ADDR-1:0]        rd_addr,
   output logic [N_CH*N_BITS-1:0]   out_data,
   output logic                     busy,
   output logic                     done,
   output logic [N_ADDR-1:0]        trig_addr
);

   localparam int W     = N_CH * N_BITS;
   localparam int DEPTH = 2 ** N_ADDR;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRE_FILL = 3'd1;
   localparam logic [2:0] S_ARMED    = 3'd2;
   localparam logic [2:0] S_POST     = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   // Counters carry one extra bit so a full-array target (DEPTH) fits.
   localparam logic [N_ADDR:0]   CNT_ZERO  = {(N_ADDR+1){1'b0}};
   localparam logic [N_ADDR:0]   CNT_ONE   = {{N_ADDR{1'b0}}, 1'b1};
   localparam logic [N_ADDR:0]   CNT_DEPTH = {1'b1, {N_ADDR{1'b0}}};
   localparam logic [N_ADDR-1:0] PTR_ZERO  = {N_ADDR{1'b0}};
   localparam logic [N_ADDR-1:0] PTR_ONE   = {{(N_ADDR-1){1'b0}}, 1'b1};

   logic [W-1:0] mem [0:DEPTH-1];

   logic [2:0]        state_r,  state_s;
   logic [N_ADDR-1:0] wr_ptr_r, wr_ptr_s;
   logic [N_ADDR-1:0] start_r,  start_s;
   logic [N_ADDR-1:0] pre_r,    pre_s;
   logic [N_ADDR:0]   cnt_r,    cnt_s;
   logic [N_ADDR:0]   target_r, target_s;
   logic              we_s;
   logic [N_ADDR-1:0] rd_phys_s;
   logic              busy_r;
   logic              done_r;

   // Next-state, pointer and counter logic for the capture FSM.
   always_comb begin
      state_s  = state_r;
      wr_ptr_s = wr_ptr_r;
      start_s  = start_r;
      pre_s    = pre_r;
      cnt_s    = cnt_r;
      target_s = target_r;
      we_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            wr_ptr_s = PTR_ZERO;
            cnt_s    = CNT_ZERO;
            if (arm) begin
               pre_s = pre_count;
               if (!mode) begin
                  state_s  = S_POST;
                  start_s  = PTR_ZERO;
                  target_s = CNT_DEPTH;
               end else if (pre_count == PTR_ZERO) begin
                  state_s = S_ARMED;
               end else begin
                  state_s = S_PRE_FILL;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_PRE_FILL: begin
            we_s = in_valid;
            if (!arm) begin
               state_s = S_IDLE;
            end else if (in_valid) begin
               cnt_s = cnt_r + CNT_ONE;
               if (cnt_s == {1'b0, pre_r}) begin
                  state_s = S_ARMED;
               end else begin
                  state_s = S_PRE_FILL;
               end
            end else begin
               state_s = S_PRE_FILL;
            end
         end
         S_ARMED: begin
            we_s = in_valid;
            if (!arm) begin
               state_s = S_IDLE;
            end else if (in_valid && trig) begin
               // Trigger vector sits at logical index pre_count.
               start_s  = wr_ptr_r - pre_r;
               target_s = CNT_DEPTH - {1'b0, pre_r};
               cnt_s    = CNT_ONE;
               if (target_s == CNT_ONE) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_POST;
               end
            end else begin
               state_s = S_ARMED;
            end
         end
         S_POST: begin
            we_s = in_valid;
            if (!arm) begin
               state_s = S_IDLE;
            end else if (in_valid) begin
               cnt_s = cnt_r + CNT_ONE;
               if (cnt_s == target_r) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_POST;
               end
            end else begin
               state_s = S_POST;
            end
         end
         S_DONE: begin
            if (!arm) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      if (we_s) begin
         wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_s = wr_ptr_s;
      end
   end

   // Logical-to-physical read address rotation.
   always_comb begin
      rd_phys_s = start_r + rd_addr;
   end

   // FSM registers and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= S_IDLE;
         wr_ptr_r <= PTR_ZERO;
         start_r  <= PTR_ZERO;
         pre_r    <= PTR_ZERO;
         cnt_r    <= CNT_ZERO;
         target_r <= CNT_ZERO;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         wr_ptr_r <= wr_ptr_s;
         start_r  <= start_s;
         pre_r    <= pre_s;
         cnt_r    <= cnt_s;
         target_r <= target_s;
         busy_r   <= (state_s == S_PRE_FILL) || (state_s == S_ARMED) ||
                     (state_s == S_POST);
         done_r   <= (state_s == S_DONE);
      end
   end

   // Sample array write port; array itself is not reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem[wr_ptr_r] <= in_data;
      end
   end

   // Registered read port, one cycle latency, active in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= {W{1'b0}};
      end else begin
         out_data <= mem[rd_phys_s];
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign trig_addr = start_r;

endmodule

// File: tb/tb_triggered_capture_memory.sv
// Directed bench for triggered_capture_memory with a small configuration
// (4 channels x 8 bits, 16-entry array). Capture scenarios come from a table;
// abort, arm-drop on the final write and async reset are hand-written.
module tb_triggered_capture_memory;

   localparam int N_CH   = 4;
   localparam int N_BITS = 8;
   localparam int N_ADDR = 4;
   localparam int W      = N_CH * N_BITS;

   logic              clk = 1'b0;
   logic              rst;
   logic [W-1:0]      in_data;
   logic              in_valid;
   logic              arm;
   logic              mode;
   logic              trig;
   logic [N_ADDR-1:0] pre_count;
   logic [N_ADDR-1:0] rd_addr;
   logic [W-1:0]      out_data;
   logic              busy;
   logic              done;
   logic [N_ADDR-1:0] trig_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit mode;
      int pre;
      int trig_k;     // valid vector index carrying the real trigger
      int ign_k;      // valid vector index with a trigger during PRE_FILL
      bit gap;        // in_valid low every 3rd cycle, trig on an invalid cycle
      int exp_last;   // last vector written before done
      int exp_ta;
      int exp_first;  // ch0 of logical address 0
   } row_t;

   row_t rows [6];

   triggered_capture_memory #(.N_CH(N_CH), .N_BITS(N_BITS), .N_ADDR(N_ADDR)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .arm(arm),
      .mode(mode), .trig(trig), .pre_count(pre_count), .rd_addr(rd_addr),
      .out_data(out_data), .busy(busy), .done(done), .trig_addr(trig_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] vec(input int k);
      logic [W-1:0] v;
      for (int i = 0; i < N_CH; i++) v[i*N_BITS +: N_BITS] = 8'(k + i);
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic run_row(input int r, input row_t rw);
      int  k;
      int  last_k;
      bit  seen;
      @(negedge clk);
      arm = 1'b0; in_valid = 1'b0; trig = 1'b0; rd_addr = '0;
      @(negedge clk);
      arm = 1'b1; mode = rw.mode; pre_count = 4'(rw.pre);
      @(negedge clk);
      check($sformatf("row%0d_busy_after_arm", r), W'(busy), W'(1));
      k = 0; last_k = -1; seen = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         in_valid = !(rw.gap && (cyc % 3 == 2));
         in_data  = vec(k);
         trig     = in_valid ? ((k == rw.trig_k) || (k == rw.ign_k)) : (rw.gap && cyc == 8);
         if (in_valid) begin
            last_k = k;
            k++;
         end
         @(negedge clk);
      end
      check($sformatf("row%0d_done_seen", r), W'(seen), W'(1));
      check($sformatf("row%0d_last_k", r), W'(last_k), W'(rw.exp_last));
      check($sformatf("row%0d_busy_done", r), W'(busy), W'(0));
      check($sformatf("row%0d_trig_addr", r), W'(trig_addr), W'(rw.exp_ta));
      // Junk with valid and trig while DONE must not disturb the array.
      in_valid = 1'b1; trig = 1'b1; in_data = 32'hEEEE_EEEE;
      for (int l = 0; l < 16; l++) begin
         rd_addr = 4'(l);
         @(negedge clk);
         check($sformatf("row%0d_rd%0d", r, l), out_data, vec(rw.exp_first + l));
      end
      check($sformatf("row%0d_done_hold", r), W'(done), W'(1));
      arm = 1'b0; in_valid = 1'b0; trig = 1'b0;
      @(negedge clk);
      check($sformatf("row%0d_done_clear", r), W'(done), W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      //          mode pre trig ign gap last ta first
      rows[0] = '{1'b0, 0, -1, -1, 1'b0, 15, 0, 0};
      rows[1] = '{1'b1, 4, 10, -1, 1'b0, 21, 6, 6};
      rows[2] = '{1'b1, 4, 10, -1, 1'b1, 21, 6, 6};
      rows[3] = '{1'b1, 4,  7,  2, 1'b0, 18, 3, 3};
      rows[4] = '{1'b1, 15, 20, -1, 1'b0, 20, 5, 5};
      rows[5] = '{1'b1, 0,  3, -1, 1'b0, 18, 3, 3};

      rst = 1'b1; in_data = '0; in_valid = 1'b0; arm = 1'b0; mode = 1'b0;
      trig = 1'b0; pre_count = '0; rd_addr = '0;
      #12;
      check("reset_busy", W'(busy), W'(0));
      check("reset_done", W'(done), W'(0));
      check("reset_trig_addr", W'(trig_addr), W'(0));
      check("reset_out_data", out_data, W'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int r = 0; r < 6; r++) run_row(r, rows[r]);

      // Async reset in ARMED; start pointer is 3 from the previous capture.
      @(negedge clk);
      arm = 1'b1; mode = 1'b1; pre_count = 4'd2; rd_addr = 4'd0;
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         in_valid = 1'b1; in_data = vec(j);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("pre_rst_busy", W'(busy), W'(1));
      check("pre_rst_trig_addr", W'(trig_addr), W'(3));
      check("pre_rst_out_data", out_data, vec(3));
      #3 rst = 1'b1;
      #1;
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_out_data", out_data, W'(0));
      check("rst_trig_addr", W'(trig_addr), W'(0));
      arm = 1'b0;
      #3 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("post_rst_busy", W'(busy), W'(0));
      check("post_rst_done", W'(done), W'(0));

      // Abort during POST, then a fresh one-shot capture.
      arm = 1'b1; mode = 1'b0;
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         in_valid = 1'b1; in_data = vec(100 + j);
         @(negedge clk);
      end
      arm = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", W'(busy), W'(0));
      check("abort_done", W'(done), W'(0));
      arm = 1'b1; mode = 1'b0;
      @(negedge clk);
      for (int j = 0; j < 16; j++) begin
         in_valid = 1'b1; in_data = vec(200 + j);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("rearm_done", W'(done), W'(1));
      check("rearm_trig_addr", W'(trig_addr), W'(0));
      rd_addr = 4'd0;
      @(negedge clk);
      check("rearm_rd0", out_data, vec(200));

      // arm dropped together with the final write: IDLE wins, write lands.
      arm = 1'b0;
      @(negedge clk);
      arm = 1'b1; mode = 1'b0;
      @(negedge clk);
      for (int j = 0; j < 16; j++) begin
         in_valid = 1'b1; in_data = vec(50 + j);
         if (j == 15) arm = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("simul_done", W'(done), W'(0));
      check("simul_busy", W'(busy), W'(0));
      rd_addr = 4'd15;
      @(negedge clk);
      check("simul_last_write", out_data, vec(65));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
